gt_phase_align_sequencer: RTL and testbench

- Multi-lane sequencer for GTX TX/RX buffer-bypass phase alignment.
- Drives one per-lane manual phase-align FSM per lane through its run/done pair.
- Aligns the master lane first, then the slave lanes one at a time in ascending index.
- Supervises each step with a timeout and bounded retry, and sits between the main reset FSM and the per-lane aligners in stable_clk_i.

---
 rtl/gt_phalign_pkg.sv | 41 ++++
 rtl/gt_phalign_timer.sv | 39 +++
 rtl/gt_phase_align_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_gt_phase_align_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_phalign_pkg.sv
// -----------------------------------------------------------------------------
// gt_phalign_pkg
//   Shared definitions for the GTX buffer-bypass phase-alignment sequencer:
//   sequencer state encoding, lane index width, timer width helper and the
//   lane-ordering function (master first, then ascending slaves).
// -----------------------------------------------------------------------------
package gt_phalign_pkg;

  localparam int LANE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CLK,
    ST_RUN_LANE,
    ST_SETTLE,
    ST_DONE,
    ST_FAIL
  } state_e;

  // One down-counter serves both the step timeout and the settle interval, so
  // it must hold whichever load value is larger.
  function automatic int timer_width(input int timeout_cycles, input int settle_cycles);
    int m;
    m = (timeout_cycles > settle_cycles) ? timeout_cycles : settle_cycles;
    return $clog2(m + 1);
  endfunction

  // Lane after 'cur' in alignment order. The master goes first, slaves follow
  // in ascending index with the master skipped. A result >= number of lanes
  // means 'cur' was the last lane.
  function automatic int next_lane(input int cur, input int master);
    int nxt;
    if (cur == master) begin
      nxt = (master == 0) ? 1 : 0;
    end else begin
      nxt = (cur + 1 == master) ? cur + 2 : cur + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gt_phalign_timer.sv
// -----------------------------------------------------------------------------
// gt_phalign_timer
//   Loadable down-counter. After a load of N, expire_o pulses in the N-th
//   enabled cycle (counter value 1), so a state that loads on entry and leaves
//   on expire_o stays resident for exactly N cycles.
// Ports:
//   stable_clk_i  clock
//   clr_i         synchronous clear (highest priority)
//   load_i        load load_val_i
//   load_val_i    cycle count to load
//   en_i          count enable
//   expire_o      one-cycle expiry pulse (combinational from the count)
// -----------------------------------------------------------------------------
module gt_phalign_timer #(
  parameter int WIDTH = 16
) (
  input  logic             stable_clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge stable_clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/gt_phase_align_sequencer.sv
// -----------------------------------------------------------------------------
// gt_phase_align_sequencer
//   Multi-lane sequencer for GTX TX/RX buffer-bypass phase alignment. Runs the
//   master lane's aligner first, then each slave lane in ascending index, with
//   a per-step timeout, bounded retry and relock on loss of clock/done.
//
// Ports (single clock domain stable_clk_i, synchronous active-high rst_i):
//   start_i          level request from the main reset FSM; low aborts
//   recclkstable_i   per-lane recovered/usr clock stable
//   lane_done_i      per-lane phase_alignment_done
//   lane_run_o       per-lane run_phalignment
//   cur_lane_o       lane currently being aligned
//   retry_cnt_o      retries consumed in the current attempt
//   busy_o           sequence in progress
//   all_aligned_o    every lane aligned
//   fail_o           retries exhausted
//
// Optional (macro GT_PHALIGN_STATUS_EN), cleared by rst_i only:
//   relock_cnt_o     saturating count of DONE-to-relock events
//   last_fail_lane_o cur_lane captured on every timeout
// -----------------------------------------------------------------------------
module gt_phase_align_sequencer
  import gt_phalign_pkg::*;
#(
  parameter  int NUM_LANES      = 4,
  parameter  int MASTER_LANE    = 0,
  parameter  int TIMEOUT_CYCLES = 65535,
  parameter  int SETTLE_CYCLES  = 16,
  parameter  int MAX_RETRIES    = 3,
  localparam int RETRY_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                 stable_clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_LANES-1:0] recclkstable_i,
  input  logic [NUM_LANES-1:0] lane_done_i,
  output logic [NUM_LANES-1:0] lane_run_o,
  output logic [3:0]           cur_lane_o,
  output logic [RETRY_W-1:0]   retry_cnt_o,
  output logic                 busy_o,
  output logic                 all_aligned_o,
  output logic                 fail_o
`ifdef GT_PHALIGN_STATUS_EN
  ,
  output logic [7:0]           relock_cnt_o,
  output logic [3:0]           last_fail_lane_o
`endif
);

  localparam int                TMR_W  = timer_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [LANE_W-1:0] MASTER = LANE_W'(MASTER_LANE);

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 abort, clk_ok, done_all, done_cur;
  logic                 advance, timeout, relock;
  logic                 tmr_load, tmr_en, expire;
  logic [TMR_W-1:0]     tmr_load_val;
  logic [NUM_LANES-1:0] cur_onehot, run_d;
  logic                 busy_d, aligned_d, fail_d;
  int                   nxt;

  assign abort    = rst_i || !start_i;
  assign clk_ok   = &recclkstable_i;
  assign done_all = &lane_done_i;

  // Decode cur lane to one-hot instead of a variable bit-select so the index
  // width never has to match the lane vector width.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      cur_onehot[i] = (lane_q == LANE_W'(i));
    end
  end
  assign done_cur = |(lane_done_i & cur_onehot);

  // ---------------------------------------------------------------------------
  // State register (outputs are registered from the next-state decode, so a
  // lane_done_i seen on one edge raises the next lane_run_o on that same edge)
  // ---------------------------------------------------------------------------
  // NOTE: all flops use non-blocking assignments so every register samples the
  // pre-edge value of every other register.
  always_ff @(posedge stable_clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      lane_q        <= MASTER;
      retry_q       <= '0;
      lane_run_o    <= '0;
      busy_o        <= 1'b0;
      all_aligned_o <= 1'b0;
      fail_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      retry_q       <= retry_d;
      lane_run_o    <= run_d;
      busy_o        <= busy_d;
      all_aligned_o <= aligned_d;
      fail_o        <= fail_d;
    end
  end

  assign cur_lane_o  = lane_q;
  assign retry_cnt_o = retry_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    retry_d = retry_q;
    advance = 1'b0;
    timeout = 1'b0;
    relock  = 1'b0;
    nxt     = next_lane(int'(lane_q), MASTER_LANE);

    if (abort) begin
      state_d = ST_IDLE;
      lane_d  = MASTER;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_CLK;

        ST_WAIT_CLK: begin
          if (clk_ok) begin
            state_d = ST_RUN_LANE;
            lane_d  = MASTER;
          end else if (expire) begin
            timeout = 1'b1;
          end
        end

        // A done seen in the expiry cycle still counts as success.
        ST_RUN_LANE: begin
          if (done_cur) begin
            advance = 1'b1;
            if (nxt >= NUM_LANES) begin
              state_d = ST_DONE;
            end else begin
              lane_d = LANE_W'(nxt);
            end
          end else if (expire || !clk_ok) begin
            timeout = 1'b1;
          end
        end

        ST_SETTLE: begin
          if (expire) begin
            state_d = ST_WAIT_CLK;
          end
        end

        // Losing a clock or a done after full alignment is a relock: it starts
        // a fresh attempt rather than consuming a retry.
        ST_DONE: begin
          if (!clk_ok || !done_all) begin
            relock  = 1'b1;
            state_d = ST_SETTLE;
          end
        end

        ST_FAIL: state_d = ST_FAIL;

        default: state_d = ST_IDLE;
      endcase

      if (relock) begin
        retry_d = '0;
      end

      if (timeout) begin
        if (retry_q < RETRY_W'(MAX_RETRIES)) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_FAIL;
        end
      end
    end
  end

  // Timer reloads on every state change and on every lane advance; only SETTLE
  // uses the short interval.
  assign tmr_load     = (state_d != state_q) || advance;
  assign tmr_load_val = (state_d == ST_SETTLE) ? TMR_W'(SETTLE_CYCLES) : TMR_W'(TIMEOUT_CYCLES);
  assign tmr_en       = (state_q == ST_WAIT_CLK) || (state_q == ST_RUN_LANE) ||
                        (state_q == ST_SETTLE);

  gt_phalign_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .stable_clk_i (stable_clk_i),
    .clr_i        (abort),
    .load_i       (tmr_load),
    .load_val_i   (tmr_load_val),
    .en_i         (tmr_en),
    .expire_o     (expire)
  );

  // ---------------------------------------------------------------------------
  // Output decode (from next state, registered above)
  // ---------------------------------------------------------------------------
  // In RUN_LANE every lane already aligned stays running: the master plus all
  // slaves up to and including the current one. Dropping run would reset that
  // lane's aligner.
  always_comb begin
    run_d     = '0;
    busy_d    = 1'b0;
    aligned_d = 1'b0;
    fail_d    = 1'b0;
    case (state_d)
      ST_WAIT_CLK, ST_SETTLE: busy_d = 1'b1;
      ST_RUN_LANE: begin
        busy_d = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          run_d[i] = (i == MASTER_LANE) || ((lane_d != MASTER) && (LANE_W'(i) <= lane_d));
        end
      end
      ST_DONE: begin
        aligned_d = 1'b1;
        run_d     = '1;
      end
      ST_FAIL: fail_d = 1'b1;
      default: ;
    endcase
  end

`ifdef GT_PHALIGN_STATUS_EN
  logic [7:0] relock_cnt_q;
  logic [3:0] last_fail_q;

  // Diagnostic history survives start_i aborts; only rst_i clears it.
  always_ff @(posedge stable_clk_i) begin
    if (rst_i) begin
      relock_cnt_q <= '0;
      last_fail_q  <= '0;
    end else begin
      if (relock && (relock_cnt_q != 8'hFF)) begin
        relock_cnt_q <= relock_cnt_q + 8'd1;
      end
      if (timeout) begin
        last_fail_q <= lane_q;
      end
    end
  end

  assign relock_cnt_o     = relock_cnt_q;
  assign last_fail_lane_o = last_fail_q;
`endif

endmodule

// File: tb/tb_gt_phase_align_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gt_phase_align_sequencer
//   Three sequencers share rst/start/recclkstable: A (4 lanes, master 0),
//   B (4 lanes, master 2) and C (single lane). Each has a behavioural lane
//   aligner model that raises done a programmable number of cycles after run.
//   lane_run_o changes are checked against queues of expected values.
// -----------------------------------------------------------------------------
module tb_gt_phase_align_sequencer;

  localparam int N  = 4;
  localparam int TO = 100;
  localparam int ST = 16;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [N-1:0] recclk = '0;

  logic [N-1:0] done_a = '0, done_b = '0, run_a, run_b;
  logic [0:0]   done_c = '0, run_c;
  logic [3:0]   cur_a, cur_b, cur_c;
  logic [1:0]   retry_a, retry_b, retry_c;
  logic         busy_a, busy_b, busy_c;
  logic         aligned_a, aligned_b, aligned_c;
  logic         fail_a, fail_b, fail_c;
`ifdef GT_PHALIGN_STATUS_EN
  logic [7:0]   relock_a, relock_b, relock_c;
  logic [3:0]   lfl_a, lfl_b, lfl_c;
`endif

  always #5 clk = ~clk;

  gt_phase_align_sequencer #(
    .NUM_LANES(N), .MASTER_LANE(0), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .MAX_RETRIES(MR)
  ) dut_a (
    .stable_clk_i(clk), .rst_i(rst), .start_i(start), .recclkstable_i(recclk),
    .lane_done_i(done_a), .lane_run_o(run_a), .cur_lane_o(cur_a), .retry_cnt_o(retry_a),
    .busy_o(busy_a), .all_aligned_o(aligned_a), .fail_o(fail_a)
`ifdef GT_PHALIGN_STATUS_EN
    , .relock_cnt_o(relock_a), .last_fail_lane_o(lfl_a)
`endif
  );

  gt_phase_align_sequencer #(
    .NUM_LANES(N), .MASTER_LANE(2), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .MAX_RETRIES(MR)
  ) dut_b (
    .stable_clk_i(clk), .rst_i(rst), .start_i(start), .recclkstable_i(recclk),
    .lane_done_i(done_b), .lane_run_o(run_b), .cur_lane_o(cur_b), .retry_cnt_o(retry_b),
    .busy_o(busy_b), .all_aligned_o(aligned_b), .fail_o(fail_b)
`ifdef GT_PHALIGN_STATUS_EN
    , .relock_cnt_o(relock_b), .last_fail_lane_o(lfl_b)
`endif
  );

  gt_phase_align_sequencer #(
    .NUM_LANES(1), .MASTER_LANE(0), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .MAX_RETRIES(MR)
  ) dut_c (
    .stable_clk_i(clk), .rst_i(rst), .start_i(start), .recclkstable_i(recclk[0:0]),
    .lane_done_i(done_c), .lane_run_o(run_c), .cur_lane_o(cur_c), .retry_cnt_o(retry_c),
    .busy_o(busy_c), .all_aligned_o(aligned_c), .fail_o(fail_c)
`ifdef GT_PHALIGN_STATUS_EN
    , .relock_cnt_o(relock_c), .last_fail_lane_o(lfl_c)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboards and lane aligner models (all updated on the falling edge)
  // ---------------------------------------------------------------------------
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic       mon_a = 1'b0, mon_b = 1'b0;
  logic [3:0] prev_a = '0, prev_b = '0;
  int         cnt_a[N], cnt_b[N], cnt_c;
  int         dly_a[N];
  logic [N-1:0] dead_a = '0;

  initial begin
    for (int i = 0; i < N; i++) begin
      dly_a[i] = 10; cnt_a[i] = 0; cnt_b[i] = 0;
    end
    cnt_c = 0;
    forever begin
      @(negedge clk);
      if (mon_a && (run_a !== prev_a)) begin
        if (q_a.size() == 0) check("run_a unexpected change", run_a, prev_a);
        else                 check("run_a sequence", run_a, q_a.pop_front());
      end
      if (mon_b && (run_b !== prev_b)) begin
        if (q_b.size() == 0) check("run_b unexpected change", run_b, prev_b);
        else                 check("run_b sequence", run_b, q_b.pop_front());
      end
      prev_a = run_a;
      prev_b = run_b;
      for (int i = 0; i < N; i++) begin
        cnt_a[i]  = (run_a[i] === 1'b1) ? cnt_a[i] + 1 : 0;
        done_a[i] = (run_a[i] === 1'b1) && !dead_a[i] && (cnt_a[i] >= dly_a[i]);
        cnt_b[i]  = (run_b[i] === 1'b1) ? cnt_b[i] + 1 : 0;
        done_b[i] = (run_b[i] === 1'b1) && (cnt_b[i] >= 10);
      end
      cnt_c     = (run_c[0] === 1'b1) ? cnt_c + 1 : 0;
      done_c[0] = (run_c[0] === 1'b1) && (cnt_c >= 5);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return aligned_a;
      1:       return fail_a;
      2:       return run_a == 4'h3;
      3:       return done_a[3];
      4:       return aligned_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int bound, input bit quiet);
    int k;
    k = 0;
    while (!sig(which) && k < bound) begin
      tick();
      k++;
    end
    if (!quiet || !sig(which)) check(name, 32'(sig(which)), 32'd1);
  endtask

  task automatic push_a(input logic [3:0] v);
    q_a.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Table: one row per cycle, checked on DUT A after the following edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] clk_ok;
    logic       busy;
    logic [3:0] run;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int k;
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0};  // reset
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0};  // IDLE -> WAIT_CLK
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0};  // clocks not stable
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h1};  // master runs
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'h0};  // abort mid RUN_LANE
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0};  // WAIT_CLK again
    vecs[6]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0};  // rst beats start
    vecs[7]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0};  // IDLE -> WAIT_CLK
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h1};  // WAIT_CLK -> RUN_LANE
    vecs[9]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h1};  // still lane 0
    vecs[10] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0};  // rst mid RUN_LANE

    tick(2);
    for (int i = 0; i < 11; i++) begin
      rst    = vecs[i].rst;
      start  = vecs[i].start;
      recclk = vecs[i].clk_ok;
      tick();
      check($sformatf("vec%0d busy", i), busy_a, vecs[i].busy);
      check($sformatf("vec%0d run", i), run_a, vecs[i].run);
      check($sformatf("vec%0d cur", i), cur_a, 4'h0);
      check($sformatf("vec%0d aligned", i), aligned_a, 1'b0);
      check($sformatf("vec%0d fail", i), fail_a, 1'b0);
    end

    // Nominal on A, non-zero master on B, single lane on C
    rst = 1'b0; start = 1'b0; recclk = 4'hF;
    tick();
    push_a(4'h1); push_a(4'h3); push_a(4'h7); push_a(4'hF);
    q_b.push_back(4'h4); q_b.push_back(4'h5); q_b.push_back(4'h7); q_b.push_back(4'hF);
    mon_a = 1'b1; mon_b = 1'b1;
    start = 1'b1;
    wait_sig("lane3 done seen", 3, 300, 1'b1);
    check("aligned before lane3 done taken", aligned_a, 1'b0);
    tick();
    check("aligned one cycle after lane3 done", aligned_a, 1'b1);
    check("nominal retry", retry_a, 2'd0);
    check("nominal busy", busy_a, 1'b0);
    check("nominal run", run_a, 4'hF);
    check("nominal cur", cur_a, 4'h3);
    wait_sig("master2 aligned", 4, 300, 1'b0);
    check("master2 cur", cur_b, 4'h3);
    mon_b = 1'b0;
    check("master2 queue drained", q_b.size(), 0);
    check("single lane aligned", aligned_c, 1'b1);
    check("single lane run", run_c, 1'b1);

    // Relock from DONE
    push_a(4'h0); push_a(4'h1); push_a(4'h3); push_a(4'h7); push_a(4'hF);
    recclk = 4'h7;
    tick();
    check("relock aligned drops", aligned_a, 1'b0);
    check("relock busy", busy_a, 1'b1);
    check("relock retry", retry_a, 2'd0);
    recclk = 4'hF;
    wait_sig("relock realigned", 0, 400, 1'b0);
    check("relock retry after", retry_a, 2'd0);

    // Done coincides with timer expiry: must advance without retry
    push_a(4'h0);
    start = 1'b0;
    tick();
`ifdef GT_PHALIGN_STATUS_EN
    check("relock count survives abort", relock_a, 8'd1);
`endif
    dly_a[1] = TO;
    push_a(4'h1); push_a(4'h3); push_a(4'h7); push_a(4'hF);
    start = 1'b1;
    wait_sig("same-cycle aligned", 0, 600, 1'b0);
    check("same-cycle retry", retry_a, 2'd0);
    dly_a[1] = 10;

    // Single timeout on lane 1, then recovery
    push_a(4'h0);
    start = 1'b0;
    tick();
    dead_a = 4'b0010;
    push_a(4'h1); push_a(4'h3); push_a(4'h0);
    push_a(4'h1); push_a(4'h3); push_a(4'h7); push_a(4'hF);
    start = 1'b1;
    wait_sig("lane1 running", 2, 100, 1'b1);
    k = 0;
    while (run_a == 4'h3 && k < 200) begin tick(); k++; end
    check("timeout length", k, TO);
    dead_a = '0;
    check("timeout retry", retry_a, 2'd1);
    check("timeout busy", busy_a, 1'b1);
    k = 0;
    while (run_a == 4'h0 && k < 100) begin tick(); k++; end
    // SETTLE interval plus the single WAIT_CLK cycle with clocks stable
    check("settle length", k, ST + 1);
    wait_sig("retry pass aligned", 0, 400, 1'b0);
    check("retry kept", retry_a, 2'd1);
`ifdef GT_PHALIGN_STATUS_EN
    check("last fail lane", lfl_a, 4'd1);
`endif

    // Retries exhausted
    push_a(4'h0);
    start = 1'b0;
    tick();
    check("abort clears retry", retry_a, 2'd0);
    dead_a = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      push_a(4'h1); push_a(4'h3); push_a(4'h0);
    end
    start = 1'b1;
    wait_sig("fail asserted", 1, 1500, 1'b0);
    check("fail run", run_a, 4'h0);
    check("fail busy", busy_a, 1'b0);
    check("fail retry", retry_a, 2'd3);
    tick(5);
    check("fail holds", fail_a, 1'b1);
    start = 1'b0;
    tick();
    check("abort clears fail", fail_a, 1'b0);
    check("abort busy", busy_a, 1'b0);
    check("abort cur", cur_a, 4'h0);
    dead_a = '0;
    check("queue drained", q_a.size(), 0);
    mon_a = 1'b0;

`ifdef GT_PHALIGN_STATUS_EN
    for (int i = 0; i < N; i++) dly_a[i] = 1;
    start = 1'b1;
    for (int i = 0; i < 260; i++) begin
      wait_sig("saturation aligned", 0, 300, 1'b1);
      recclk = 4'h7;
      tick();
      recclk = 4'hF;
    end
    check("relock count saturates", relock_a, 8'd255);
    rst = 1'b1;
    tick();
    check("rst clears relock count", relock_a, 8'd0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
